// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-write controller.
// Optional ACK checking in sccb_wr_ctrl is enabled by defining SCCB_ACK_CHK_EN.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } sccb_state_e;

  localparam int unsigned BYTES_PER_WR  = 4;
  localparam int unsigned BITS_PER_BYTE = 8;

  // sys_clk cycles per quarter SCL bit period
  function automatic int unsigned calc_cnt_q(input int unsigned sys_clk_freq,
                                             input int unsigned scl_freq);
    return sys_clk_freq / (scl_freq * 4);
  endfunction

endpackage

// File: rtl/sccb_wr_ctrl_if.sv
// Request handshake and SCCB bus signals of the register-write controller.
// slave: controller side; master: requester / bus side.
interface sccb_wr_ctrl_if;
  logic        cfg_start;
  logic [23:0] cfg_data;
  logic        cfg_end;
  logic        busy;
  logic        ack_err;
  logic        scl;
  logic        sda_out;
  logic        sda_oe;
  logic        sda_in;

  modport slave (
    input  cfg_start, cfg_data, sda_in,
    output cfg_end, busy, ack_err, scl, sda_out, sda_oe
  );

  modport master (
    output cfg_start, cfg_data, sda_in,
    input  cfg_end, busy, ack_err, scl, sda_out, sda_oe
  );
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit divider: tick pulses every CNT_Q cycles while enabled,
// counter held at zero while disabled so each transfer starts phase-aligned.
module sccb_tick_gen #(
  parameter int unsigned CNT_Q = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CNT_W   = (CNT_Q > 1) ? $clog2(CNT_Q) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_Q - 1);

  logic [CNT_W-1:0] cnt;

  // free-running modulo-CNT_Q counter, cleared when disabled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/sccb_wr_ctrl.sv
// SCCB 3-phase register write: START, 4 bytes each followed by an ACK slot, STOP.
// Optional feature macro SCCB_ACK_CHK_EN: a NACK aborts to STOP and flags ack_err.
module sccb_wr_ctrl
  import sccb_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ     = 250_000,
  parameter logic [6:0]  DEV_ADDR     = 7'h3C
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  sccb_wr_ctrl_if.slave  bus
);

`ifdef SCCB_ACK_CHK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  localparam int unsigned CNT_Q     = calc_cnt_q(SYS_CLK_FREQ, SCL_FREQ);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WR - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  sccb_state_e state;
  logic [1:0]  q_idx;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [23:0] cfg_q;
  logic [7:0]  cur_byte;
  logic        tick;
  logic        nack;
  logic        err_q;
  logic        scl_q;
  logic        sda_oe_q;
  logic        cfg_end_q;
  logic        busy_q;
  logic        ack_err_q;
  logic        scl_lvl;
  logic        sda_lvl;

  sccb_tick_gen #(
    .CNT_Q (CNT_Q)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (state != ST_IDLE),
    .tick      (tick)
  );

  // byte currently on the wire, in transmission order
  always_comb begin
    cur_byte = {DEV_ADDR, 1'b0};
    case (byte_idx)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = cfg_q[23:16];
      2'd2:    cur_byte = cfg_q[15:8];
      default: cur_byte = cfg_q[7:0];
    endcase
  end

  // target SCL/SDA line levels for the current state and quarter
  always_comb begin
    scl_lvl = 1'b1;
    sda_lvl = 1'b1;
    case (state)
      ST_START: begin
        scl_lvl = (q_idx != 2'd3);
        sda_lvl = (q_idx < 2'd2);
      end
      ST_BYTE: begin
        scl_lvl = (q_idx == 2'd1) || (q_idx == 2'd2);
        sda_lvl = cur_byte[bit_idx];
      end
      ST_ACK: begin
        scl_lvl = (q_idx == 2'd1) || (q_idx == 2'd2);
        sda_lvl = 1'b1;
      end
      ST_STOP: begin
        scl_lvl = (q_idx != 2'd0);
        sda_lvl = q_idx[1];
      end
      default: ;
    endcase
  end

  // transaction sequencer with registered bus and handshake outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      q_idx     <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      cfg_q     <= '0;
      nack      <= 1'b0;
      err_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      cfg_end_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      scl_q    <= scl_lvl;
      sda_oe_q <= ~sda_lvl;
      case (state)
        ST_IDLE: begin
          cfg_end_q <= 1'b0;
          ack_err_q <= 1'b0;
          if (bus.cfg_start) begin
            cfg_q    <= bus.cfg_data;
            busy_q   <= 1'b1;
            state    <= ST_START;
            q_idx    <= '0;
            byte_idx <= '0;
            bit_idx  <= LAST_BIT;
            nack     <= 1'b0;
            err_q    <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_DONE: begin
          cfg_end_q <= 1'b1;
          ack_err_q <= err_q;
          state     <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            q_idx <= q_idx + 2'd1;
            if ((state == ST_ACK) && (q_idx == 2'd2)) begin
              nack <= bus.sda_in;
            end
            if (q_idx == 2'd3) begin
              case (state)
                ST_START: state <= ST_BYTE;
                ST_BYTE: begin
                  if (bit_idx == '0) begin
                    state <= ST_ACK;
                  end else begin
                    bit_idx <= bit_idx - 3'd1;
                  end
                end
                ST_ACK: begin
                  bit_idx <= LAST_BIT;
                  if (ACK_CHK && nack) begin
                    err_q <= 1'b1;
                    state <= ST_STOP;
                  end else if (byte_idx == LAST_BYTE) begin
                    state <= ST_STOP;
                  end else begin
                    byte_idx <= byte_idx + 2'd1;
                    state    <= ST_BYTE;
                  end
                end
                ST_STOP: state <= ST_DONE;
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.scl     = scl_q;
  assign bus.sda_oe  = sda_oe_q;
  assign bus.sda_out = 1'b0;
  assign bus.cfg_end = cfg_end_q;
  assign bus.busy    = busy_q;
  assign bus.ack_err = ACK_CHK ? ack_err_q : 1'b0;

endmodule

// File: tb/tb_sccb_wr_ctrl.sv
// Self-checking bench for sccb_wr_ctrl: an SCCB bus monitor decodes frames from
// the wire, a slave model answers ACK slots, and expectations come from the
// frame rules (bytes, bit-period counts, NACK behaviour).
`timescale 1ns/1ps
module tb_sccb_wr_ctrl;

`ifdef SCCB_ACK_CHK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  localparam int unsigned CNT_Q   = 50;      // 50 MHz / (4 * 250 kHz)
  localparam int unsigned TIMEOUT = 9000;
  localparam logic [7:0]  WR_ADDR = 8'h78;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  sccb_wr_ctrl_if bus();

  sccb_wr_ctrl #(
    .SYS_CLK_FREQ (50_000_000),
    .SCL_FREQ     (250_000),
    .DEV_ADDR     (7'h3C)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // slave side: ack_mask[i] = 1 means the slave pulls SDA low in byte i's ACK slot
  logic [3:0]  ack_mask  = 4'hF;
  logic        slave_low = 1'b0;
  assign bus.sda_in = bus.sda_oe ? bus.sda_out : ~slave_low;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // bus monitor state
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  bit          in_frame = 1'b0;
  bit          ack_done = 1'b0;
  int unsigned bitcnt   = 0;
  int unsigned nb       = 0;
  logic [7:0]  sh       = '0;
  logic [31:0] cur_b    = '0;
  int unsigned frame_nb[$];
  logic [31:0] frame_b[$];
  int unsigned od_viol  = 0;
  int unsigned stray_err = 0;

  always @(negedge sys_clk) begin
    logic sda_now;
    sda_now = bus.sda_in;
    if (!sys_rst_n) begin
      in_frame  = 1'b0;
      ack_done  = 1'b0;
      slave_low = 1'b0;
    end else begin
      if (bus.sda_out !== 1'b0) od_viol++;
      if (bus.ack_err && !bus.cfg_end) stray_err++;
      if (prev_scl && bus.scl && prev_sda && !sda_now) begin
        in_frame = 1'b1; bitcnt = 0; nb = 0; cur_b = '0; ack_done = 1'b0;
      end else if (prev_scl && bus.scl && !prev_sda && sda_now) begin
        if (in_frame) begin
          frame_nb.push_back(nb);
          frame_b.push_back(cur_b);
        end
        in_frame = 1'b0; slave_low = 1'b0;
      end else if (!prev_scl && bus.scl && in_frame) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda_now};
          bitcnt++;
          if (bitcnt == 8) begin
            if (nb < 4) cur_b[31 - 8*nb -: 8] = sh;
            nb++;
          end
        end else begin
          bitcnt = 0;
          ack_done = 1'b1;
        end
      end else if (prev_scl && !bus.scl && in_frame) begin
        if (ack_done) begin
          slave_low = 1'b0;
          ack_done  = 1'b0;
        end else if (bitcnt == 8 && nb >= 1 && nb <= 4) begin
          slave_low = ack_mask[nb-1];
        end
      end
    end
    prev_scl = bus.scl;
    prev_sda = sda_now;
  end

  // expected frame length: with ACK checking, stop after the first NACKed byte
  function automatic int unsigned exp_nbytes(input logic [3:0] mask);
    if (!ACK_CHK) return 4;
    for (int unsigned i = 0; i < 4; i++) if (!mask[i]) return i + 1;
    return 4;
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic start_req(input logic [23:0] d);
    bus.cfg_data  = d;
    bus.cfg_start = 1'b1;
    @(posedge sys_clk); #1;
    bus.cfg_start = 1'b0;
  endtask

  // wait for cfg_end; optionally inject an extra request inject_at cycles in
  task automatic wait_end(input int unsigned inject_at, input logic [23:0] inj,
                          output int unsigned lat, output logic err,
                          output int unsigned busy_low);
    lat = 0; err = 1'b0; busy_low = 0;
    for (int unsigned n = 1; n <= TIMEOUT; n++) begin
      @(posedge sys_clk); #1;
      bus.cfg_start = 1'b0;
      if (n == inject_at) begin
        bus.cfg_data  = inj;
        bus.cfg_start = 1'b1;
      end
      if (!bus.busy) busy_low++;
      if (bus.cfg_end) begin
        lat = n;
        err = bus.ack_err;
        break;
      end
    end
  endtask

  task automatic do_xfer(input string tag, input logic [23:0] d, input int unsigned inject_at);
    int unsigned lat, busy_low, enb, nbits;
    logic        err;
    logic [31:0] keep;
    enb   = exp_nbytes(ack_mask);
    nbits = 2 + 9 * enb;
    keep  = 32'hFFFF_FFFF << (8 * (4 - enb));
    start_req(d);
    wait_end(inject_at, ~d, lat, err, busy_low);
    check_eq({tag, "_latency"}, lat, nbits * 4 * CNT_Q + 1);
    check_eq({tag, "_ack_err"}, {31'd0, err}, {31'd0, ACK_CHK && (ack_mask != 4'hF)});
    check_eq({tag, "_busy_gap"}, busy_low, 0);
    check_eq({tag, "_frames"}, frame_nb.size(), 1);
    if (frame_nb.size() != 0) begin
      check_eq({tag, "_nbytes"}, frame_nb.pop_front(), enb);
      check_eq({tag, "_bytes"}, frame_b.pop_front(), {WR_ADDR, d} & keep);
    end
  endtask

  initial begin
    int unsigned ends, busy_hi;
    bus.cfg_start = 1'b0;
    bus.cfg_data  = '0;
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("rst_scl", bus.scl, 1);
    check_eq("rst_sda_oe", bus.sda_oe, 0);
    check_eq("rst_sda_out", bus.sda_out, 0);
    check_eq("rst_cfg_end", bus.cfg_end, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ack_err", bus.ack_err, 0);
    idle(3);
    sys_rst_n = 1'b1;
    idle(3);

    // basic write with a second request 100 cycles in that must be ignored
    ack_mask = 4'hF;
    do_xfer("basic", 24'h300882, 100);
    ends = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk); #1;
      if (bus.cfg_end) ends++;
    end
    check_eq("single_end", ends, 0);
    check_eq("idle_busy", bus.busy, 0);

    // back-to-back: second request issued in the cfg_end cycle
    do_xfer("b2b_a", 24'h123456, 0);
    do_xfer("b2b_b", 24'h310311, 0);
    idle(10);

    // reset 3000 cycles into a transfer
    start_req(24'h5A5A5A);
    repeat (3000) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check_eq("midrst_scl", bus.scl, 1);
    check_eq("midrst_sda_oe", bus.sda_oe, 0);
    check_eq("midrst_busy", bus.busy, 0);
    idle(3);
    sys_rst_n = 1'b1;
    ends = 0; busy_hi = 0;
    for (int i = 0; i < 4800; i++) begin
      @(posedge sys_clk); #1;
      if (bus.cfg_end) ends++;
      if (bus.busy) busy_hi++;
    end
    check_eq("midrst_no_end", ends, 0);
    check_eq("midrst_no_busy", busy_hi, 0);
    check_eq("midrst_no_frame", frame_nb.size(), 0);
    do_xfer("post_rst", 24'hC0FFEE, 0);
    idle(10);

    // slave never acknowledges (SDA stays high)
    ack_mask = 4'h0;
    do_xfer("sda_high", 24'hA5C3E1, 0);
    idle(10);

    // slave NACKs byte 2
    ack_mask = 4'b1101;
    do_xfer("nack_b2", 24'h0F1E2D, 0);
    idle(10);

    // randomized data and slave responses
    for (int i = 0; i < 2; i++) begin
      ack_mask = 4'($urandom_range(0, 15));
      do_xfer("rand", 24'($urandom), 0);
      idle(5 + $urandom_range(0, 20));
    end

    check_eq("open_drain", od_viol, 0);
    check_eq("stray_ack_err", stray_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
